// File: rtl/mbx_pkg.sv
// Types and helpers shared by the mailbox blocks.
package mbx_pkg;

    typedef enum logic {
        WrIdle = 1'b0,
        WrReq  = 1'b1
    } mbx_wr_state_e;

    // Byte stride between consecutive mailbox words.
    function automatic int unsigned mbx_stride(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/mbx_writer.sv
// Mailbox write side: turns system word writes into single-word SRAM writes
// inside the [base, limit] window and reports close/last-word status.
module mbx_writer
    import mbx_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrWidth-1:0] range_base_i,
    input  logic [AddrWidth-1:0] range_limit_i,
    input  logic                 sys_wr_valid_i,
    input  logic [DataWidth-1:0] sys_wr_data_i,
    output logic                 sys_wr_ready_o,
    input  logic                 sys_go_i,
    input  logic                 mbx_clear_i,
    output logic                 sram_req_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    input  logic                 sram_gnt_i,
    output logic                 mbx_range_valid_o,
    output logic                 writer_write_valid_o,
    output logic                 writer_close_mbx_o,
    output logic                 writer_last_word_written_o,
    output logic                 wr_error_o,
    output logic [AddrWidth-1:0] wr_ptr_o
);

    localparam int unsigned          Stride    = mbx_stride(DataWidth);
    localparam logic [AddrWidth-1:0] StrideA   = AddrWidth'(Stride);
    localparam logic [AddrWidth-1:0] AlignMask = AddrWidth'(Stride - 1);

    mbx_wr_state_e        state_q, state_d;
    logic [AddrWidth-1:0] ptr_q;
    logic                 active_q;
    logic                 close_q;
    logic                 wrap_q;
    logic                 err_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q;

    logic                 range_valid;
    logic [AddrWidth-1:0] wr_addr;
    logic                 in_window;
    logic                 ready;
    logic                 accept;
    logic                 grant;
    logic [AddrWidth:0]   next_ptr;

    assign range_valid = (range_base_i <= range_limit_i)
                       && ((range_base_i & AlignMask) == '0)
                       && ((range_limit_i & AlignMask) == '0);

    assign wr_addr = active_q ? ptr_q : range_base_i;

    // Once the pointer has wrapped past all-ones it is treated as beyond the limit.
    assign in_window = range_valid && !(active_q && wrap_q) && (wr_addr <= range_limit_i);

    assign ready    = (state_q == WrIdle) && !close_q;
    assign accept   = sys_wr_valid_i && ready;
    assign grant    = (state_q == WrReq) && sram_gnt_i;
    assign next_ptr = {1'b0, addr_q} + {1'b0, StrideA};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= WrIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (mbx_clear_i) begin
            state_d = WrIdle;
        end else begin
            case (state_q)
                WrIdle:  if (accept && in_window) state_d = WrReq;
                WrReq:   if (sram_gnt_i)          state_d = WrIdle;
                default: state_d = WrIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q    <= '0;
            active_q <= 1'b0;
            close_q  <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (mbx_clear_i) begin
            // Clear overrides any same-cycle accept, go or grant.
            ptr_q    <= range_base_i;
            active_q <= 1'b0;
            close_q  <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (sys_go_i) close_q <= 1'b1;
            if (accept && in_window) begin
                addr_q   <= wr_addr;
                wdata_q  <= sys_wr_data_i;
                active_q <= 1'b1;
            end
            err_q <= accept && !in_window;
            if (grant) begin
                ptr_q  <= next_ptr[AddrWidth-1:0];
                wrap_q <= wrap_q | next_ptr[AddrWidth];
            end
        end
    end

    assign sys_wr_ready_o             = ready;
    assign sram_req_o                 = (state_q == WrReq);
    assign sram_addr_o                = addr_q;
    assign sram_wdata_o               = wdata_q;
    assign mbx_range_valid_o          = range_valid;
    assign writer_write_valid_o       = grant && !mbx_clear_i;
    assign writer_close_mbx_o         = close_q;
    assign writer_last_word_written_o = close_q && (state_q == WrIdle);
    assign wr_error_o                 = err_q;
    assign wr_ptr_o                   = ptr_q;

endmodule

// File: tb/tb_mbx_writer.sv
// Directed bench for mbx_writer with an SRAM-write scoreboard.
module tb_mbx_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] base, limit;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        ready;
    logic        go, clr;
    logic        req;
    logic [31:0] addr, wdata;
    logic        gnt;
    logic        rvalid, wvalid, close_mbx, last, err;
    logic [31:0] wr_ptr;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic        m_active;
    logic [31:0] m_ptr;

    mbx_writer #(.AddrWidth(32), .DataWidth(32)) dut (
        .clk_i                      (clk),
        .rst_ni                     (rst_n),
        .range_base_i               (base),
        .range_limit_i              (limit),
        .sys_wr_valid_i             (wr_valid),
        .sys_wr_data_i              (wr_data),
        .sys_wr_ready_o             (ready),
        .sys_go_i                   (go),
        .mbx_clear_i                (clr),
        .sram_req_o                 (req),
        .sram_addr_o                (addr),
        .sram_wdata_o               (wdata),
        .sram_gnt_i                 (gnt),
        .mbx_range_valid_o          (rvalid),
        .writer_write_valid_o       (wvalid),
        .writer_close_mbx_o         (close_mbx),
        .writer_last_word_written_o (last),
        .wr_error_o                 (err),
        .wr_ptr_o                   (wr_ptr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_active = 1'b0;
        m_ptr    = base;
        #1;
        chk("clear_ptr", wr_ptr, base);
        chk("clear_close", close_mbx, 1'b0);
    endtask

    // Offer one word while idle; ok says whether the model expects it in the window.
    task automatic accept(input logic [31:0] d, input bit ok, input logic with_go);
        exp_t e;
        wr_valid = 1'b1;
        wr_data  = d;
        go       = with_go;
        #1;
        chk("ready_idle", ready, 1'b1);
        if (ok) begin
            e.addr = m_active ? m_ptr : base;
            e.data = d;
            sb.push_back(e);
            m_active = 1'b1;
        end
        tick();
        wr_valid = 1'b0;
        go       = 1'b0;
        #1;
        if (ok) begin
            chk("req_after_accept", req, 1'b1);
            chk("ready_in_req", ready, 1'b0);
        end else begin
            chk("err_pulse", err, 1'b1);
            chk("no_req_on_err", req, 1'b0);
            tick();
            chk("err_single", err, 1'b0);
            chk("no_req_later", req, 1'b0);
        end
    endtask

    // Hold grant off for delay cycles, then grant and score the SRAM write.
    task automatic grant(input int delay, input bit closed);
        exp_t e;
        chk("sb_size", sb.size(), 1);
        if (sb.size() == 0) return;
        for (int i = 0; i < delay; i++) begin
            chk("req_held", req, 1'b1);
            chk("addr_stable", addr, sb[0].addr);
            chk("ready_held_low", ready, 1'b0);
            if (closed) begin
                chk("close_wait", close_mbx, 1'b1);
                chk("last_wait", last, 1'b0);
            end
            tick();
        end
        gnt = 1'b1;
        #1;
        e = sb.pop_front();
        chk("wvalid_on_gnt", wvalid, 1'b1);
        chk("sram_addr", addr, e.addr);
        chk("sram_wdata", wdata, e.data);
        tick();
        gnt = 1'b0;
        #1;
        m_ptr = e.addr + 32'd4;
        chk("req_drop", req, 1'b0);
        chk("wvalid_single", wvalid, 1'b0);
        chk("ptr_step", wr_ptr, m_ptr);
        chk("ready_after", ready, !closed);
        chk("last_after", last, closed);
    endtask

    initial begin
        rst_n    = 1'b0;
        base     = 32'h1000;
        limit    = 32'h100C;
        wr_valid = 1'b0;
        wr_data  = '0;
        go       = 1'b0;
        clr      = 1'b0;
        gnt      = 1'b0;
        m_active = 1'b0;
        m_ptr    = 32'h0;
        #3;
        chk("rst_req", req, 1'b0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_close", close_mbx, 1'b0);
        chk("rst_last", last, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ptr", wr_ptr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Four words, grant same cycle as request.
        chk("range_ok", rvalid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            accept(32'hA000_0000 + 32'(i), 1'b1, 1'b0);
            grant(0, 1'b0);
        end
        chk("ptr_after4", wr_ptr, 32'h1010);

        // Fifth word falls outside the window.
        accept(32'hDEAD_0005, 1'b0, 1'b0);
        chk("ptr_hold", wr_ptr, 32'h1010);

        // Go while grant is held off three cycles.
        do_clear();
        accept(32'h1111_2222, 1'b1, 1'b0);
        go = 1'b1;
        tick();
        go = 1'b0;
        #1;
        grant(3, 1'b1);
        wr_valid = 1'b1;
        #1;
        chk("ready_closed", ready, 1'b0);
        tick();
        wr_valid = 1'b0;
        #1;
        chk("no_req_closed", req, 1'b0);

        // Inverted and misaligned windows.
        base  = 32'h1010;
        limit = 32'h1000;
        do_clear();
        chk("range_inverted", rvalid, 1'b0);
        accept(32'h5555_5555, 1'b0, 1'b0);
        base  = 32'h1002;
        limit = 32'h100C;
        #1;
        chk("range_misaligned", rvalid, 1'b0);

        // Clear with go during WrReq; next write restarts at base.
        base  = 32'h2000;
        limit = 32'h200C;
        do_clear();
        accept(32'h0000_0001, 1'b1, 1'b0);
        grant(1, 1'b0);
        accept(32'h0000_0002, 1'b1, 1'b0);
        clr = 1'b1;
        go  = 1'b1;
        gnt = 1'b1;
        #1;
        chk("wvalid_clr_wins", wvalid, 1'b0);
        tick();
        clr = 1'b0;
        go  = 1'b0;
        gnt = 1'b0;
        void'(sb.pop_back());
        m_active = 1'b0;
        m_ptr    = base;
        #1;
        chk("clr_req_low", req, 1'b0);
        chk("clr_close_low", close_mbx, 1'b0);
        chk("clr_ptr_base", wr_ptr, 32'h2000);
        accept(32'h0000_0003, 1'b1, 1'b0);
        grant(0, 1'b0);

        // Go together with an accepted write.
        accept(32'h0000_0004, 1'b1, 1'b1);
        chk("close_next", close_mbx, 1'b1);
        chk("last_low_req", last, 1'b0);
        grant(0, 1'b1);

        // Pointer wrap past all-ones reads as beyond limit.
        base  = 32'hFFFF_FFF8;
        limit = 32'hFFFF_FFFC;
        do_clear();
        accept(32'hC0DE_0001, 1'b1, 1'b0);
        grant(0, 1'b0);
        accept(32'hC0DE_0002, 1'b1, 1'b0);
        grant(0, 1'b0);
        chk("ptr_wrapped", wr_ptr, 32'h0);
        accept(32'hC0DE_0003, 1'b0, 1'b0);

        // Asynchronous reset in WrReq.
        base  = 32'h3000;
        limit = 32'h300C;
        do_clear();
        accept(32'hFACE_0001, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        chk("arst_req", req, 1'b0);
        chk("arst_addr", addr, 32'h0);
        chk("arst_wdata", wdata, 32'h0);
        chk("arst_ready", ready, 1'b1);
        chk("arst_ptr", wr_ptr, 32'h0);
        chk("arst_last", last, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_req", req, 1'b0);
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
